// File: rtl/maxpool_layer.sv
// maxpool_layer: streaming 2x2 / stride-2 max-pool between the conv layer and
// the next layer's input buffer. One line buffer of IMG_DIM/2 entries per
// channel holds the horizontal maxima of the even row; the odd row combines
// with it and emits one pooled pixel per 2x2 window, one cycle after the beat.
// Optional build macro POOL_RELU_EN: clamp negative pooled values to zero.

// Per-channel datapath: horizontal pair register, line buffer, vertical max.
module maxpool_lane #(
  parameter int DATA_SIZE = 8,
  parameter int OUT_DIM   = 13,
  parameter int LB_AW     = 4
) (
  input  logic                 clk,
  input  logic                 hreg_we,
  input  logic                 lb_we,
  input  logic [LB_AW-1:0]     lb_idx,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] pool
);
  logic signed [DATA_SIZE-1:0] hreg, h, lb_rd, mx;
  logic signed [DATA_SIZE-1:0] linebuf [OUT_DIM];

  // Even column parks its pixel; even row stores the horizontal max per pair.
  always_ff @(posedge clk) begin
    if (hreg_we) hreg <= din;
    if (lb_we)   linebuf[lb_idx] <= h;
  end

  // Signed horizontal max of the pair, then vertical max against the line buffer.
  always_comb begin
    h     = ($signed(din) > hreg) ? $signed(din) : hreg;
    lb_rd = linebuf[lb_idx];
    mx    = (lb_rd > h) ? lb_rd : h;
  end

  // Optional clamp of negative results; same cycle, no extra latency.
  always_comb begin
`ifdef POOL_RELU_EN
    pool = mx[DATA_SIZE-1] ? '0 : mx;
`else
    pool = mx;
`endif
  end
endmodule

module maxpool_layer #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_DIM   = 26,
  parameter int CHANNELS  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0]                 i_we,
  input  logic [CHANNELS-1:0][DATA_SIZE-1:0]  i_data,
  input  logic                                i_start,
  output logic                                o_ready,
  input  logic                                i_next_ready,
  output logic [CHANNELS-1:0][DATA_SIZE-1:0]  o_next_data,
  output logic [CHANNELS-1:0]                 o_next_we,
  output logic                                o_next_start
);
  localparam int OUT_DIM   = IMG_DIM / 2;
  localparam int CNT_WIDTH = $clog2(IMG_DIM);
  localparam int LB_AW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(IMG_DIM - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                              state, next_state;
  logic [CNT_WIDTH-1:0]                col, row;
  logic [LB_AW-1:0]                    lb_idx;
  logic [CHANNELS-1:0][DATA_SIZE-1:0]  pool;
  logic                                beat, load, start_set;
  logic                                unused_ok;

  // Only bit 0 of the write-enable vector qualifies a beat.
  assign unused_ok = &{1'b0, i_we};

  // A beat that coincides with i_start is dropped along with the partial frame.
  assign beat   = i_we[0] && o_ready && !i_start;
  assign load   = beat && col[0] && row[0];
  assign lb_idx = LB_AW'(col >> 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    maxpool_lane #(
      .DATA_SIZE (DATA_SIZE),
      .OUT_DIM   (OUT_DIM),
      .LB_AW     (LB_AW)
    ) u_lane (
      .clk     (clk),
      .hreg_we (beat && !col[0]),
      .lb_we   (beat && col[0] && !row[0]),
      .lb_idx  (lb_idx),
      .din     (i_data[g]),
      .pool    (pool[g])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: start a frame on the first beat, drain on i_start.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!i_start && beat) next_state = RUN;
      RUN:     if (i_start) next_state = FLUSH;
      FLUSH:   if (!o_next_we[0] || i_next_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: upstream ready and the end-of-frame pulse request.
  always_comb begin
    o_ready   = (state != FLUSH) && (i_next_ready || !o_next_we[0]);
    start_set = ((state == IDLE) && i_start) ||
                ((state == FLUSH) && (!o_next_we[0] || i_next_ready));
  end

  // Raster counters; odd trailing column/row simply never reach an odd/odd slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (i_start && state != FLUSH) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output register: load a new window (even while one is being taken), else
  // drop the valid once the downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_next_data  <= '0;
      o_next_we    <= '0;
      o_next_start <= 1'b0;
    end else begin
      o_next_start <= start_set;
      if (load) begin
        o_next_data <= pool;
        o_next_we   <= '1;
      end else if (i_next_ready) begin
        o_next_we   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: a 4x4, 4-channel instance driven from a
// per-cycle vector table, plus a 5x5 single-channel instance for the odd-size case.
module tb_maxpool_layer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4x4, 4 channels
  logic            a_rst, a_start, a_nrdy, a_rdy, a_ostart;
  logic [3:0]      a_we, a_owe;
  logic [3:0][7:0] a_data, a_odata;

  // 5x5, 1 channel
  logic            b_rst, b_start, b_nrdy, b_rdy, b_ostart;
  logic [0:0]      b_we, b_owe;
  logic [0:0][7:0] b_data, b_odata;

  maxpool_layer #(.DATA_SIZE(8), .IMG_DIM(4), .CHANNELS(4)) dut_a (
    .clk(clk), .rst(a_rst), .i_we(a_we), .i_data(a_data), .i_start(a_start),
    .o_ready(a_rdy), .i_next_ready(a_nrdy), .o_next_data(a_odata),
    .o_next_we(a_owe), .o_next_start(a_ostart));

  maxpool_layer #(.DATA_SIZE(8), .IMG_DIM(5), .CHANNELS(1)) dut_b (
    .clk(clk), .rst(b_rst), .i_we(b_we), .i_data(b_data), .i_start(b_start),
    .o_ready(b_rdy), .i_next_ready(b_nrdy), .o_next_data(b_odata),
    .o_next_we(b_owe), .o_next_start(b_ostart));

  // One clock of stimulus for dut_a: inputs, ready expected before the edge,
  // registered outputs expected after it (edat is channel 0 before clamping).
  typedef struct {
    int rst, we, start, nrdy, d;
    int erdy, ewe, estart, edat;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_b[4] = '{6, 8, 16, 18};
  int   got_beat[$];
  int   got_data[$];

  function automatic void v(input int rst, input int we, input int start, input int nrdy,
                            input int d, input int erdy, input int ewe, input int estart,
                            input int edat);
    vec_t t;
    t.rst = rst; t.we = we; t.start = start; t.nrdy = nrdy; t.d = d;
    t.erdy = erdy; t.ewe = ewe; t.estart = estart; t.edat = edat;
    tbl.push_back(t);
  endfunction

  // Raster ramp pixel=i*mult on a 4x4 map with no backpressure: windows close
  // on beats 5, 7, 13, 15 and their max is the bottom-right pixel.
  function automatic void ramp(input int first, input int last, input int mult);
    for (int i = first; i <= last; i++) begin
      if (i == 5 || i == 7 || i == 13 || i == 15) v(0, 1, 0, 1, i * mult, 1, 1, 0, i * mult);
      else                                        v(0, 1, 0, 1, i * mult, 1, 0, 0, 0);
    end
  endfunction

  // i_start, then one FLUSH cycle (a stray write is offered and must be refused)
  // whose edge raises the end-of-frame pulse.
  function automatic void end_frame();
    v(0, 0, 1, 1, 0,  1, 0, 0, 0);
    v(0, 1, 0, 1, 77, 0, 0, 1, 0);
  endfunction

  function automatic int exp_ch(input int raw, input int k);
    int e;
    e = raw + 16 * k;
`ifdef POOL_RELU_EN
    if (e < 0) e = 0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // plain ramp frame
    ramp(0, 15, 1);
    end_frame();
    // signed window {-3,-8,-1,-128}, then a second window of zeros; the frame
    // is cut after two rows
    v(0, 1, 0, 1, -3,   1, 0, 0, 0);
    v(0, 1, 0, 1, -8,   1, 0, 0, 0);
    v(0, 1, 0, 1, 0,    1, 0, 0, 0);
    v(0, 1, 0, 1, 0,    1, 0, 0, 0);
    v(0, 1, 0, 1, -1,   1, 0, 0, 0);
    v(0, 1, 0, 1, -128, 1, 1, 0, -1);
    v(0, 1, 0, 1, 0,    1, 0, 0, 0);
    v(0, 1, 0, 1, 0,    1, 1, 0, 0);
    end_frame();
    // backpressure: first result held 5 cycles while beat 6 waits
    ramp(0, 5, 1);
    for (int i = 0; i < 5; i++) v(0, 1, 0, 0, 6, 0, 1, 0, 5);
    v(0, 1, 0, 1, 6, 1, 0, 0, 0);
    ramp(7, 15, 1);
    end_frame();
    // reset after 9 beats, then a fresh frame
    ramp(0, 8, 2);
    v(1, 1, 0, 1, 99, 1, 0, 0, 0);
    ramp(0, 15, 2);
    end_frame();
    // i_start while idle
    v(0, 0, 1, 1, 0, 1, 0, 1, 0);
    v(0, 0, 0, 1, 0, 1, 0, 0, 0);

    a_rst = 1'b1; a_we = '0; a_start = 1'b0; a_nrdy = 1'b1; a_data = '0;
    b_rst = 1'b1; b_we = '0; b_start = 1'b0; b_nrdy = 1'b1; b_data = '0;
    @(posedge clk); #1;
    chk("reset a_we",    int'(a_owe),    0);
    chk("reset a_start", int'(a_ostart), 0);
    chk("reset a_data",  int'(a_odata),  0);
    chk("reset b_we",    int'(b_owe),    0);
    chk("reset b_start", int'(b_ostart), 0);

    @(negedge clk);
    b_rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clk);
      a_rst   = (tbl[n].rst != 0);
      a_we    = (tbl[n].we != 0) ? 4'hf : 4'h0;
      a_start = (tbl[n].start != 0);
      a_nrdy  = (tbl[n].nrdy != 0);
      for (int k = 0; k < 4; k++) a_data[k] = 8'(tbl[n].d + 16 * k);
      #1;
      chk($sformatf("v%0d ready", n), int'(a_rdy), tbl[n].erdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d we", n), int'(a_owe), (tbl[n].ewe != 0) ? 15 : 0);
      chk($sformatf("v%0d start", n), int'(a_ostart), tbl[n].estart);
      if (tbl[n].ewe != 0) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("v%0d data ch%0d", n, k), int'($signed(a_odata[k])), exp_ch(tbl[n].edat, k));
      end else if (tbl[n].rst != 0) begin
        chk($sformatf("v%0d reset data", n), int'(a_odata), 0);
      end
    end
    @(negedge clk);
    a_rst = 1'b0; a_we = '0; a_start = 1'b0;

    // 5x5 ramp: last column and row are discarded
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      b_we = 1'b1;
      b_data[0] = 8'(i);
      #1;
      chk($sformatf("b beat%0d ready", i), int'(b_rdy), 1);
      @(posedge clk); #1;
      if (b_owe[0]) begin
        got_beat.push_back(i);
        got_data.push_back(int'(b_odata[0]));
      end
    end
    @(negedge clk);
    b_we = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    begin
      int got;
      got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        @(posedge clk); #1;
        if (b_ostart) got = 1;
        if (b_owe[0]) got_beat.push_back(99);
      end
      chk("b end-of-frame pulse", got, 1);
    end
    chk("b output count", got_beat.size(), 4);
    for (int j = 0; j < 4 && j < got_beat.size(); j++) begin
      chk($sformatf("b out%0d beat", j), got_beat[j], exp_b[j]);
      chk($sformatf("b out%0d data", j), got_data[j], exp_b[j]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
